sv39_micro_tlb: RTL and testbench



---
 rtl/sv39_micro_tlb.sv | 181 ++++++++++++++++++
 tb/tb_sv39_micro_tlb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv39_micro_tlb.sv
// Sv39 micro-TLB: fully-associative, 4K/2M/1G pages, ASID + global tagging,
// tree pseudo-LRU replacement and selective SFENCE.VMA flush.
package sv39_micro_tlb_pkg;
  localparam int unsigned VLEN           = 39;
  localparam int unsigned ASID_MAX_WIDTH = 16;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef struct packed {
    logic                      valid;
    logic                      is_2M;
    logic                      is_1G;
    logic [26:0]               vpn;
    logic [ASID_MAX_WIDTH-1:0] asid;
    pte_t                      content;
  } tlb_update_t;
endpackage

module sv39_micro_tlb
  import sv39_micro_tlb_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = 4,
  parameter int unsigned ASID_WIDTH  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  tlb_update_t           update_i,
  input  logic                  lu_access_i,
  input  logic [ASID_WIDTH-1:0] lu_asid_i,
  input  logic [VLEN-1:0]       lu_vaddr_i,
  output pte_t                  lu_content_o,
  output logic                  lu_is_2M_o,
  output logic                  lu_is_1G_o,
  output logic                  lu_hit_o,
  input  logic [ASID_WIDTH-1:0] asid_to_be_flushed_i,
  input  logic [VLEN-1:0]       vaddr_to_be_flushed_i
);
  localparam int unsigned IDX_W  = $clog2(TLB_ENTRIES);
  localparam int unsigned PLRU_W = TLB_ENTRIES - 1;

  logic [TLB_ENTRIES-1:0] valid_q, is_2m_q, is_1g_q;
  logic [8:0]             vpn2_q    [TLB_ENTRIES];
  logic [8:0]             vpn1_q    [TLB_ENTRIES];
  logic [8:0]             vpn0_q    [TLB_ENTRIES];
  logic [ASID_WIDTH-1:0]  asid_q    [TLB_ENTRIES];
  pte_t                   content_q [TLB_ENTRIES];
  logic [PLRU_W-1:0]      plru_q, plru_d;

  logic [TLB_ENTRIES-1:0] lu_match, fl_match;
  logic [IDX_W-1:0]       hit_idx, free_idx, victim_idx, refill_idx;
  logic                   refill, fl_asid_zero, fl_vpn_zero;
  logic                   unused_bits;

  assign unused_bits = ^{lu_vaddr_i[11:0], vaddr_to_be_flushed_i[11:0], update_i.asid};

  function automatic logic page_match(input logic [8:0] e2, input logic [8:0] e1,
                                      input logic [8:0] e0, input logic big2m,
                                      input logic big1g, input logic [26:0] vpn);
    return (e2 == vpn[26:18]) &&
           (big1g || ((e1 == vpn[17:9]) && (big2m || (e0 == vpn[8:0]))));
  endfunction

  // Walk root-to-leaf toward idx, pointing each node at the other subtree.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [IDX_W-1:0]  idx);
    logic [PLRU_W-1:0] b;
    logic [IDX_W-1:0]  node;
    logic [IDX_W-1:0]  path;
    logic              dir;
    b    = bits;
    node = '0;
    path = idx;
    for (int l = 0; l < int'(IDX_W); l++) begin
      dir     = path[IDX_W-1];
      b[node] = ~dir;
      node    = IDX_W'(2 * node + 1 + dir);
      path    = path << 1;
    end
    return b;
  endfunction

  assign fl_asid_zero = (asid_to_be_flushed_i == '0);
  assign fl_vpn_zero  = (vaddr_to_be_flushed_i[38:12] == '0);

  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_match
    assign lu_match[i] = valid_q[i] &&
                         ((asid_q[i] == lu_asid_i) || content_q[i].g) &&
                         page_match(vpn2_q[i], vpn1_q[i], vpn0_q[i], is_2m_q[i],
                                    is_1g_q[i], lu_vaddr_i[38:12]);
    assign fl_match[i] = valid_q[i] &&
                         (fl_asid_zero ||
                          (!content_q[i].g && (asid_q[i] == asid_to_be_flushed_i))) &&
                         (fl_vpn_zero ||
                          page_match(vpn2_q[i], vpn1_q[i], vpn0_q[i], is_2m_q[i],
                                     is_1g_q[i], vaddr_to_be_flushed_i[38:12]));
  end

  // Lookup outputs; lowest matching index wins.
  always_comb begin
    lu_hit_o     = |lu_match;
    lu_content_o = '0;
    lu_is_2M_o   = 1'b0;
    lu_is_1G_o   = 1'b0;
    hit_idx      = '0;
    for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
      if (lu_match[i]) begin
        hit_idx      = IDX_W'(i);
        lu_content_o = content_q[i];
        lu_is_2M_o   = is_2m_q[i];
        lu_is_1G_o   = is_1g_q[i];
      end
    end
  end

  always_comb begin
    logic [IDX_W-1:0] node;
    free_idx   = '0;
    victim_idx = '0;
    node       = '0;
    for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
    for (int l = 0; l < int'(IDX_W); l++) begin
      victim_idx = IDX_W'({victim_idx, plru_q[node]});
      node       = IDX_W'(2 * node + 1 + plru_q[node]);
    end
  end

  assign refill     = update_i.valid && !flush_i;
  assign refill_idx = (&valid_q) ? victim_idx : free_idx;

  // A same-cycle refill is applied after the lookup hit so it ends up MRU.
  always_comb begin
    plru_d = plru_q;
    if (lu_access_i && lu_hit_o) plru_d = plru_touch(plru_d, hit_idx);
    if (refill)                  plru_d = plru_touch(plru_d, refill_idx);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      is_2m_q <= '0;
      is_1g_q <= '0;
      plru_q  <= '0;
      for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
        vpn2_q[i]    <= '0;
        vpn1_q[i]    <= '0;
        vpn0_q[i]    <= '0;
        asid_q[i]    <= '0;
        content_q[i] <= '0;
      end
    end else begin
      plru_q <= plru_d;
      if (flush_i) begin
        valid_q <= valid_q & ~fl_match;
      end else if (update_i.valid) begin
        valid_q[refill_idx]   <= 1'b1;
        is_2m_q[refill_idx]   <= update_i.is_2M;
        is_1g_q[refill_idx]   <= update_i.is_1G;
        vpn2_q[refill_idx]    <= update_i.vpn[26:18];
        vpn1_q[refill_idx]    <= update_i.vpn[17:9];
        vpn0_q[refill_idx]    <= update_i.vpn[8:0];
        asid_q[refill_idx]    <= update_i.asid[ASID_WIDTH-1:0];
        content_q[refill_idx] <= update_i.content;
      end
    end
  end
endmodule

// File: tb/tb_sv39_micro_tlb.sv
// Bench for sv39_micro_tlb: directed scenarios plus random traffic checked
// against an entry-list reference model with interval-halving pseudo-LRU.
module tb_sv39_micro_tlb;
  import sv39_micro_tlb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  tlb_update_t       upd;
  logic              lu_access;
  logic [AW-1:0]     lu_asid;
  logic [VLEN-1:0]   lu_vaddr;
  pte_t              lu_content;
  logic              lu_is_2m, lu_is_1g, lu_hit;
  logic [AW-1:0]     fl_asid;
  logic [VLEN-1:0]   fl_vaddr;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          valid;
    bit          is2m;
    bit          is1g;
    bit [26:0]   vpn;
    bit [AW-1:0] asid;
    pte_t        pte;
  } ment_t;

  ment_t m [N];
  bit    mlru [N-1];

  sv39_micro_tlb #(.TLB_ENTRIES(N), .ASID_WIDTH(AW)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .flush_i              (flush),
    .update_i             (upd),
    .lu_access_i          (lu_access),
    .lu_asid_i            (lu_asid),
    .lu_vaddr_i           (lu_vaddr),
    .lu_content_o         (lu_content),
    .lu_is_2M_o           (lu_is_2m),
    .lu_is_1G_o           (lu_is_1g),
    .lu_hit_o             (lu_hit),
    .asid_to_be_flushed_i (fl_asid),
    .vaddr_to_be_flushed_i(fl_vaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic pte_t mk_pte(input logic [43:0] ppn, input bit g);
    pte_t p;
    p     = '0;
    p.ppn = ppn;
    p.g   = g;
    p.r   = 1'b1;
    p.v   = 1'b1;
    return p;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m[i].valid = 1'b0;
    for (int i = 0; i < N - 1; i++) mlru[i] = 1'b0;
  endfunction

  // An entry covers every vpn that agrees with it above its page-size boundary.
  function automatic bit covers(input ment_t e, input bit [26:0] vpn);
    int sh;
    sh = e.is1g ? 18 : (e.is2m ? 9 : 0);
    return ((e.vpn ^ vpn) >> sh) == 27'd0;
  endfunction

  function automatic int model_hit(input bit [26:0] vpn, input bit [AW-1:0] asid);
    for (int i = 0; i < N; i++)
      if (m[i].valid && (m[i].asid == asid || m[i].pte.g) && covers(m[i], vpn)) return i;
    return -1;
  endfunction

  function automatic void model_touch(input int idx);
    int lo, hi, node, mid;
    lo = 0; hi = N; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (idx < mid) begin mlru[node] = 1'b1; hi = mid; node = 2 * node + 1; end
      else           begin mlru[node] = 1'b0; lo = mid; node = 2 * node + 2; end
    end
  endfunction

  function automatic int model_victim();
    int lo, hi, node, mid;
    for (int i = 0; i < N; i++) if (!m[i].valid) return i;
    lo = 0; hi = N; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (!mlru[node]) begin hi = mid; node = 2 * node + 1; end
      else             begin lo = mid; node = 2 * node + 2; end
    end
    return lo;
  endfunction

  // Compare lookup outputs against the model, advance the model, then clock.
  task automatic tick();
    int          h, v;
    logic [65:0] exp_o;
    bit [26:0]   fv;
    bit          aok, vok;
    #1;
    h = model_hit(lu_vaddr[38:12], lu_asid);
    exp_o = '0;
    if (h >= 0) exp_o = {m[h].is1g, m[h].is2m, m[h].pte};
    check("model.hit", lu_hit, (h >= 0));
    check("model.out", {lu_is_1g, lu_is_2m, lu_content}, exp_o);
    if (lu_access && h >= 0) model_touch(h);
    if (flush) begin
      fv = fl_vaddr[38:12];
      for (int i = 0; i < N; i++) begin
        aok = (fl_asid == '0) || (!m[i].pte.g && m[i].asid == fl_asid);
        vok = (fv == '0) || covers(m[i], fv);
        if (aok && vok) m[i].valid = 1'b0;
      end
    end else if (upd.valid) begin
      v = model_victim();
      m[v].valid = 1'b1;
      m[v].is2m  = upd.is_2M;
      m[v].is1g  = upd.is_1G;
      m[v].vpn   = upd.vpn;
      m[v].asid  = upd.asid[AW-1:0];
      m[v].pte   = upd.content;
      model_touch(v);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic refill(input logic [26:0] vpn, input logic [AW-1:0] asid, input bit s2m,
                        input bit s1g, input logic [43:0] ppn, input bit g);
    upd         = '0;
    upd.valid   = 1'b1;
    upd.is_2M   = s2m;
    upd.is_1G   = s1g;
    upd.vpn     = vpn;
    upd.asid    = ASID_MAX_WIDTH'(asid);
    upd.content = mk_pte(ppn, g);
    tick();
    upd = '0;
  endtask

  task automatic do_flush(input logic [AW-1:0] a, input logic [VLEN-1:0] va);
    fl_asid = a; fl_vaddr = va; flush = 1'b1;
    tick();
    flush = 1'b0; fl_asid = '0; fl_vaddr = '0;
  endtask

  task automatic access(input logic [VLEN-1:0] va, input logic [AW-1:0] a);
    lu_vaddr = va; lu_asid = a; lu_access = 1'b1;
    tick();
    lu_access = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [VLEN-1:0] va, input logic [AW-1:0] a,
                       input bit exp_hit, input logic [43:0] exp_ppn);
    lu_vaddr = va; lu_asid = a; lu_access = 1'b0;
    #1;
    check({tag, ".hit"}, lu_hit, exp_hit);
    if (exp_hit) check({tag, ".ppn"}, lu_content.ppn, exp_ppn);
    tick();
  endtask

  function automatic logic [VLEN-1:0] rand_va();
    logic [VLEN-1:0] va;
    va        = '0;
    va[38:30] = 9'($urandom_range(0, 1));
    va[29:21] = 9'($urandom_range(0, 1));
    va[20:12] = 9'($urandom_range(0, 3));
    va[11:0]  = 12'($urandom);
    return va;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VLEN-1:0] tva;
    int              r;
    rst_n = 1'b0; flush = 1'b0; upd = '0; lu_access = 1'b0;
    lu_asid = '0; lu_vaddr = '0; fl_asid = '0; fl_vaddr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    lu_vaddr = 39'h1000;
    #1;
    check("rst.hit", lu_hit, 1'b0);
    check("rst.out", {lu_is_1g, lu_is_2m, lu_content}, 66'h0);
    @(negedge clk);
    rst_n = 1'b1;

    probe("basic.empty", 39'h1000, 2'd1, 1'b0, 44'h0);
    refill(27'h1, 2'd1, 1'b0, 1'b0, 44'h80000, 1'b0);
    probe("basic.hit", 39'h1abc, 2'd1, 1'b1, 44'h80000);
    probe("basic.asid", 39'h1abc, 2'd0, 1'b0, 44'h0);

    refill(27'(2 << 18), 2'd1, 1'b0, 1'b1, 44'h40000, 1'b0);
    refill({9'd3, 9'd5, 9'd0}, 2'd1, 1'b1, 1'b0, 44'h50000, 1'b0);
    probe("super.1g", 39'h0_8123_4567, 2'd1, 1'b1, 44'h40000);
    probe("super.2m", 39'h0_C0A0_0000, 2'd1, 1'b1, 44'h50000);
    probe("super.miss", 39'h0_C0C0_0000, 2'd1, 1'b0, 44'h0);
    do_flush('0, '0);

    refill(27'h10, 2'd1, 1'b0, 1'b0, 44'h777, 1'b1);
    probe("glob.any", 39'h10000, 2'd0, 1'b1, 44'h777);
    do_flush(2'd1, '0);
    probe("glob.kept", 39'h10000, 2'd0, 1'b1, 44'h777);
    do_flush('0, '0);
    probe("glob.gone", 39'h10000, 2'd0, 1'b0, 44'h0);

    for (int k = 1; k <= 4; k++) refill(27'(k), 2'd1, 1'b0, 1'b0, 44'(32'h100 + k), 1'b0);
    access(39'h1000, 2'd1);
    access(39'h3000, 2'd1);
    access(39'h2000, 2'd1);
    refill(27'h5, 2'd1, 1'b0, 1'b0, 44'h105, 1'b0);
    probe("repl.evict4", 39'h4000, 2'd1, 1'b0, 44'h0);
    probe("repl.keep1", 39'h1000, 2'd1, 1'b1, 44'h101);
    probe("repl.keep2", 39'h2000, 2'd1, 1'b1, 44'h102);
    probe("repl.keep3", 39'h3000, 2'd1, 1'b1, 44'h103);
    probe("repl.new5", 39'h5000, 2'd1, 1'b1, 44'h105);
    do_flush('0, '0);

    refill(27'h7, 2'd1, 1'b0, 1'b0, 44'h71, 1'b0);
    refill(27'h7, 2'd2, 1'b0, 1'b0, 44'h72, 1'b0);
    do_flush(2'd2, 39'h7000);
    probe("fva.a1", 39'h7000, 2'd1, 1'b1, 44'h71);
    probe("fva.a2", 39'h7000, 2'd2, 1'b0, 44'h0);
    do_flush('0, 39'h7000);
    probe("fva.all", 39'h7000, 2'd1, 1'b0, 44'h0);

    refill(27'h8, 2'd1, 1'b0, 1'b0, 44'h888, 1'b0);
    upd = '0; upd.valid = 1'b1; upd.vpn = 27'h9; upd.asid = ASID_MAX_WIDTH'(1);
    upd.content = mk_pte(44'h999, 1'b0);
    flush = 1'b1; fl_asid = '0; fl_vaddr = '0;
    lu_vaddr = 39'h8000; lu_asid = 2'd1; lu_access = 1'b1;
    #1;
    check("coll.old", lu_hit, 1'b1);
    check("coll.oldppn", lu_content.ppn, 44'h888);
    tick();
    upd = '0; flush = 1'b0; lu_access = 1'b0;
    probe("coll.new", 39'h9000, 2'd1, 1'b0, 44'h0);
    probe("coll.old", 39'h8000, 2'd1, 1'b0, 44'h0);

    refill(27'h42, 2'd1, 1'b0, 1'b0, 44'h123, 1'b0);
    lu_vaddr = 39'h42000; lu_asid = 2'd1;
    #1;
    check("arst.pre", lu_hit, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("arst.hit", lu_hit, 1'b0);
    check("arst.ppn", lu_content.ppn, 44'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 800; c++) begin
      upd = '0; flush = 1'b0; lu_access = 1'b0;
      lu_vaddr = rand_va();
      lu_asid  = AW'($urandom_range(0, 3));
      r = $urandom_range(0, 19);
      if (r == 0) begin
        flush    = 1'b1;
        fl_asid  = $urandom_range(0, 1) ? '0 : AW'($urandom);
        fl_vaddr = $urandom_range(0, 1) ? '0 : rand_va();
      end else if (r <= 7) begin
        tva         = rand_va();
        r           = $urandom_range(0, 3);
        upd.valid   = 1'b1;
        upd.is_1G   = (r == 0);
        upd.is_2M   = (r == 1);
        upd.vpn     = tva[38:12];
        upd.asid    = ASID_MAX_WIDTH'($urandom_range(0, 3));
        upd.content = mk_pte(44'($urandom), ($urandom_range(0, 5) == 0));
      end else begin
        lu_access = 1'($urandom_range(0, 1));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
